// File: rtl/ex_mem_pipe.sv
// Elastic EX/MEM pipeline stage: valid/ready handshake with a main and a skid entry,
// synchronous flush, bubble gating of the MEM/WB controls, forwarding taps and a stall counter.
module ex_mem_pipe #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_reg_write,
    input  logic              in_mem_to_reg,
    input  logic              in_mem_write,
    input  logic              in_mem_read,
    input  logic [DATA_W-1:0] in_result,
    input  logic [DATA_W-1:0] in_rt_data,
    input  logic [REG_W-1:0]  in_dst_reg,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_reg_write,
    output logic              out_mem_to_reg,
    output logic              out_mem_write,
    output logic              out_mem_read,
    output logic [DATA_W-1:0] out_result,
    output logic [DATA_W-1:0] out_rt_data,
    output logic [REG_W-1:0]  out_dst_reg,
    output logic              fwd_valid,
    output logic [REG_W-1:0]  fwd_dst_reg,
    output logic [DATA_W-1:0] fwd_result,
    output logic              fwd_load_hazard,
    output logic [CNT_W-1:0]  stall_cycles
);

    localparam int PAY_W = 4 + 2 * DATA_W + REG_W;

    logic [PAY_W-1:0] in_pay_s;
    logic [PAY_W-1:0] main_pay_q, main_pay_d;
    logic [PAY_W-1:0] skid_pay_q, skid_pay_d;
    logic             main_valid_q, main_valid_d;
    logic             skid_valid_q, skid_valid_d;
    logic             in_ready_q, in_ready_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic             accept_s;
    logic             consume_s;
    logic [3:0]       main_ctrl_s;
    logic             dst_nonzero_s;

    assign in_pay_s = {in_reg_write, in_mem_to_reg, in_mem_write, in_mem_read,
                       in_result, in_rt_data, in_dst_reg};
    assign {main_ctrl_s, out_result, out_rt_data, out_dst_reg} = main_pay_q;

    // Handshake qualifiers; a flush drops whatever EX offers this cycle.
    always_comb begin
        accept_s  = in_valid & in_ready_q & ~flush;
        consume_s = main_valid_q & out_ready;
    end

    // Next-state for the two entries and the stall counter; FIFO order main -> skid.
    always_comb begin
        main_pay_d   = main_pay_q;
        skid_pay_d   = skid_pay_q;
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!main_valid_q) begin
            if (accept_s) begin
                main_pay_d   = in_pay_s;
                main_valid_d = 1'b1;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (consume_s) begin
            if (skid_valid_q) begin
                main_pay_d   = skid_pay_q;
                skid_valid_d = 1'b0;
            end else if (accept_s) begin
                main_pay_d   = in_pay_s;
            end else begin
                main_valid_d = 1'b0;
            end
        end else begin
            if (accept_s) begin
                skid_pay_d   = in_pay_s;
                skid_valid_d = 1'b1;
            end else begin
                skid_valid_d = skid_valid_q;
            end
        end
        // Registered copy of the skid state keeps in_ready free of any out_ready path.
        in_ready_d = ~skid_valid_d;
        if (main_valid_q && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
            stall_d = stall_q + CNT_W'(1);
        end else begin
            stall_d = stall_q;
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            main_pay_q   <= {PAY_W{1'b0}};
            skid_pay_q   <= {PAY_W{1'b0}};
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
            stall_q      <= {CNT_W{1'b0}};
        end else begin
            main_pay_q   <= main_pay_d;
            skid_pay_q   <= skid_pay_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
            stall_q      <= stall_d;
        end
    end

    // Output decode: bubbles carry no control, forwarding taps come from the main entry.
    always_comb begin
        if (main_valid_q) begin
            {out_reg_write, out_mem_to_reg, out_mem_write, out_mem_read} = main_ctrl_s;
        end else begin
            {out_reg_write, out_mem_to_reg, out_mem_write, out_mem_read} = 4'b0000;
        end
        dst_nonzero_s   = (out_dst_reg != {REG_W{1'b0}});
        fwd_valid       = main_valid_q & out_reg_write & ~out_mem_read & dst_nonzero_s;
        fwd_load_hazard = main_valid_q & out_mem_read & dst_nonzero_s;
        fwd_dst_reg     = out_dst_reg;
        fwd_result      = out_result;
        out_valid       = main_valid_q;
        in_ready        = in_ready_q;
        stall_cycles    = stall_q;
    end

endmodule

// File: tb/tb_ex_mem_pipe.sv
// Bench for ex_mem_pipe: directed table, randomized run against a queue-based model,
// and a counter-saturation sequence on a narrow-counter instance.
module tb_ex_mem_pipe;

    logic        clk;
    logic        rst_n, flush, in_valid, out_ready;
    logic        in_reg_write, in_mem_to_reg, in_mem_write, in_mem_read;
    logic [31:0] in_result, in_rt_data;
    logic [4:0]  in_dst_reg;

    logic        in_ready, out_valid, out_reg_write, out_mem_to_reg, out_mem_write, out_mem_read;
    logic [31:0] out_result, out_rt_data, fwd_result;
    logic [4:0]  out_dst_reg, fwd_dst_reg;
    logic        fwd_valid, fwd_load_hazard;
    logic [15:0] stall_cycles;

    logic        s_in_ready, s_out_valid, s_rw, s_m2r, s_mw, s_mr, s_fwd_valid, s_lh;
    logic [31:0] s_out_result, s_out_rt_data, s_fwd_result;
    logic [4:0]  s_out_dst_reg, s_fwd_dst_reg;
    logic [3:0]  s_stall_cycles;

    ex_mem_pipe dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_reg_write(in_reg_write), .in_mem_to_reg(in_mem_to_reg), .in_mem_write(in_mem_write),
        .in_mem_read(in_mem_read), .in_result(in_result), .in_rt_data(in_rt_data),
        .in_dst_reg(in_dst_reg), .out_valid(out_valid), .out_ready(out_ready),
        .out_reg_write(out_reg_write), .out_mem_to_reg(out_mem_to_reg),
        .out_mem_write(out_mem_write), .out_mem_read(out_mem_read), .out_result(out_result),
        .out_rt_data(out_rt_data), .out_dst_reg(out_dst_reg), .fwd_valid(fwd_valid),
        .fwd_dst_reg(fwd_dst_reg), .fwd_result(fwd_result), .fwd_load_hazard(fwd_load_hazard),
        .stall_cycles(stall_cycles)
    );

    ex_mem_pipe #(.DATA_W(32), .REG_W(5), .CNT_W(4)) dut_sat (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_reg_write(in_reg_write), .in_mem_to_reg(in_mem_to_reg), .in_mem_write(in_mem_write),
        .in_mem_read(in_mem_read), .in_result(in_result), .in_rt_data(in_rt_data),
        .in_dst_reg(in_dst_reg), .out_valid(s_out_valid), .out_ready(out_ready),
        .out_reg_write(s_rw), .out_mem_to_reg(s_m2r), .out_mem_write(s_mw), .out_mem_read(s_mr),
        .out_result(s_out_result), .out_rt_data(s_out_rt_data), .out_dst_reg(s_out_dst_reg),
        .fwd_valid(s_fwd_valid), .fwd_dst_reg(s_fwd_dst_reg), .fwd_result(s_fwd_result),
        .fwd_load_hazard(s_lh), .stall_cycles(s_stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: a queue of at most two bundles plus the last bundle seen at the head.
    typedef struct packed {
        logic [3:0]  ctrl;   // {reg_write, mem_to_reg, mem_write, mem_read}
        logic [31:0] res;
        logic [31:0] rt;
        logic [4:0]  dst;
    } bundle_t;

    bundle_t     mq[$];
    bundle_t     last_b;
    int unsigned stall_m;

    task automatic model_step();
        bundle_t b;
        bit      acc;
        b = '{ctrl: {in_reg_write, in_mem_to_reg, in_mem_write, in_mem_read},
               res: in_result, rt: in_rt_data, dst: in_dst_reg};
        if (!rst_n) begin
            mq.delete();
            last_b  = '0;
            stall_m = 0;
        end else begin
            if (mq.size() > 0 && !out_ready && stall_m < 65535) stall_m++;
            if (flush) begin
                mq.delete();
            end else begin
                acc = in_valid && (mq.size() < 2);
                if (mq.size() > 0 && out_ready) void'(mq.pop_front());
                if (acc) mq.push_back(b);
            end
            if (mq.size() > 0) last_b = mq[0];
        end
    endtask

    task automatic model_check();
        bit         v;
        logic [3:0] ec;
        bit         nz;
        v  = (mq.size() > 0);
        ec = v ? last_b.ctrl : 4'b0000;
        nz = (last_b.dst != 5'd0);
        chk("out_valid", 64'(out_valid), 64'(v));
        chk("in_ready", 64'(in_ready), 64'(mq.size() < 2));
        chk("out_ctrl", 64'({out_reg_write, out_mem_to_reg, out_mem_write, out_mem_read}), 64'(ec));
        chk("out_result", 64'(out_result), 64'(last_b.res));
        chk("out_rt_data", 64'(out_rt_data), 64'(last_b.rt));
        chk("out_dst_reg", 64'(out_dst_reg), 64'(last_b.dst));
        chk("fwd_valid", 64'(fwd_valid), 64'(v && ec[3] && !ec[0] && nz));
        chk("fwd_load_hazard", 64'(fwd_load_hazard), 64'(v && ec[0] && nz));
        chk("fwd_dst_reg", 64'(fwd_dst_reg), 64'(last_b.dst));
        chk("fwd_result", 64'(fwd_result), 64'(last_b.res));
        chk("stall_cycles", 64'(stall_cycles), 64'(stall_m));
        chk("stall_sat", 64'(s_stall_cycles), 64'((stall_m > 15) ? 15 : stall_m));
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        model_check();
    endtask

    typedef struct {
        bit          rst_n, flush, iv, ordy;
        logic [3:0]  ctrl;
        logic [31:0] res;
        logic [4:0]  dst;
        bit          e_valid, e_ready;
        logic [31:0] e_res;
        logic [15:0] e_stall;
        bit          e_fwd, e_lh;
    } vec_t;

    function automatic vec_t mk(bit r, bit f, bit iv, bit o, logic [3:0] c, logic [31:0] res,
                                logic [4:0] d, bit ev, bit er, logic [31:0] eres,
                                logic [15:0] es, bit efw, bit elh);
        vec_t t;
        t = '{rst_n: r, flush: f, iv: iv, ordy: o, ctrl: c, res: res, dst: d, e_valid: ev,
              e_ready: er, e_res: eres, e_stall: es, e_fwd: efw, e_lh: elh};
        return t;
    endfunction

    task automatic drive(bit r, bit f, bit iv, bit o, logic [3:0] c, logic [31:0] res,
                         logic [31:0] rt, logic [4:0] d);
        rst_n = r; flush = f; in_valid = iv; out_ready = o;
        {in_reg_write, in_mem_to_reg, in_mem_write, in_mem_read} = c;
        in_result = res; in_rt_data = rt; in_dst_reg = d;
    endtask

    vec_t tbl[19];

    initial begin
        //            rst flu iv  ordy ctrl     res        dst    val rdy e_res      stall fwd lh
        tbl[0]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 4'b1000, 32'h99,  5'd2, 1'b0, 1'b1, 32'h0,  16'd0, 1'b0, 1'b0);
        tbl[1]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 4'b1000, 32'h99,  5'd2, 1'b0, 1'b1, 32'h0,  16'd0, 1'b0, 1'b0);
        tbl[2]  = mk(1'b1, 1'b0, 1'b1, 1'b1, 4'b1000, 32'h10,  5'd2, 1'b1, 1'b1, 32'h10, 16'd0, 1'b1, 1'b0);
        tbl[3]  = mk(1'b1, 1'b0, 1'b1, 1'b1, 4'b1000, 32'h20,  5'd2, 1'b1, 1'b1, 32'h20, 16'd0, 1'b1, 1'b0);
        tbl[4]  = mk(1'b1, 1'b0, 1'b1, 1'b1, 4'b1000, 32'h30,  5'd2, 1'b1, 1'b1, 32'h30, 16'd0, 1'b1, 1'b0);
        tbl[5]  = mk(1'b1, 1'b0, 1'b0, 1'b1, 4'b1000, 32'h0,   5'd2, 1'b0, 1'b1, 32'h30, 16'd0, 1'b0, 1'b0);
        tbl[6]  = mk(1'b1, 1'b0, 1'b1, 1'b0, 4'b1000, 32'h11,  5'd2, 1'b1, 1'b1, 32'h11, 16'd0, 1'b1, 1'b0);
        tbl[7]  = mk(1'b1, 1'b0, 1'b1, 1'b0, 4'b1000, 32'h22,  5'd2, 1'b1, 1'b0, 32'h11, 16'd1, 1'b1, 1'b0);
        tbl[8]  = mk(1'b1, 1'b0, 1'b1, 1'b0, 4'b1000, 32'h77,  5'd2, 1'b1, 1'b0, 32'h11, 16'd2, 1'b1, 1'b0);
        tbl[9]  = mk(1'b1, 1'b0, 1'b0, 1'b1, 4'b1000, 32'h0,   5'd2, 1'b1, 1'b1, 32'h22, 16'd2, 1'b1, 1'b0);
        tbl[10] = mk(1'b1, 1'b0, 1'b0, 1'b1, 4'b1000, 32'h0,   5'd2, 1'b0, 1'b1, 32'h22, 16'd2, 1'b0, 1'b0);
        tbl[11] = mk(1'b1, 1'b0, 1'b1, 1'b0, 4'b1000, 32'h44,  5'd2, 1'b1, 1'b1, 32'h44, 16'd2, 1'b1, 1'b0);
        tbl[12] = mk(1'b1, 1'b0, 1'b1, 1'b0, 4'b1000, 32'h55,  5'd2, 1'b1, 1'b0, 32'h44, 16'd3, 1'b1, 1'b0);
        tbl[13] = mk(1'b1, 1'b1, 1'b1, 1'b0, 4'b1000, 32'h33,  5'd2, 1'b0, 1'b1, 32'h44, 16'd4, 1'b0, 1'b0);
        tbl[14] = mk(1'b1, 1'b0, 1'b0, 1'b1, 4'b1000, 32'h0,   5'd2, 1'b0, 1'b1, 32'h44, 16'd4, 1'b0, 1'b0);
        tbl[15] = mk(1'b1, 1'b0, 1'b1, 1'b1, 4'b1101, 32'h100, 5'd8, 1'b1, 1'b1, 32'h100, 16'd4, 1'b0, 1'b1);
        tbl[16] = mk(1'b1, 1'b0, 1'b1, 1'b1, 4'b1000, 32'h66,  5'd0, 1'b1, 1'b1, 32'h66, 16'd4, 1'b0, 1'b0);
        tbl[17] = mk(1'b1, 1'b0, 1'b1, 1'b1, 4'b1000, 32'h55,  5'd9, 1'b1, 1'b1, 32'h55, 16'd4, 1'b1, 1'b0);
        tbl[18] = mk(1'b1, 1'b0, 1'b0, 1'b1, 4'b1000, 32'h0,   5'd9, 1'b0, 1'b1, 32'h55, 16'd4, 1'b0, 1'b0);

        mq.delete();
        last_b  = '0;
        stall_m = 0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 32'h0, 32'h0, 5'd0);

        for (int i = 0; i < 19; i++) begin
            drive(tbl[i].rst_n, tbl[i].flush, tbl[i].iv, tbl[i].ordy, tbl[i].ctrl,
                  tbl[i].res, ~tbl[i].res, tbl[i].dst);
            cycle();
            chk($sformatf("tbl%0d_valid", i), 64'(out_valid), 64'(tbl[i].e_valid));
            chk($sformatf("tbl%0d_ready", i), 64'(in_ready), 64'(tbl[i].e_ready));
            chk($sformatf("tbl%0d_result", i), 64'(out_result), 64'(tbl[i].e_res));
            chk($sformatf("tbl%0d_stall", i), 64'(stall_cycles), 64'(tbl[i].e_stall));
            chk($sformatf("tbl%0d_fwd", i), 64'(fwd_valid), 64'(tbl[i].e_fwd));
            chk($sformatf("tbl%0d_lhaz", i), 64'(fwd_load_hazard), 64'(tbl[i].e_lh));
        end

        // Randomized traffic with occasional reset and flush.
        for (int i = 0; i < 600; i++) begin
            drive(($urandom_range(0, 63) != 0), ($urandom_range(0, 15) == 0),
                  ($urandom_range(0, 1) == 1), ($urandom_range(0, 9) < 6),
                  4'($urandom_range(0, 15)), $urandom, $urandom, 5'($urandom_range(0, 31)));
            cycle();
        end

        // Counter saturation: hold one entry under backpressure for 20 cycles.
        drive(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 32'h0, 32'h0, 5'd0);
        cycle();
        drive(1'b1, 1'b0, 1'b1, 1'b0, 4'b1000, 32'hABC, 32'h1, 5'd3);
        cycle();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 4'b1000, 32'h0, 32'h0, 5'd3);
        for (int i = 0; i < 20; i++) cycle();
        chk("sat_stall_4bit", 64'(s_stall_cycles), 64'(15));
        chk("sat_stall_16bit", 64'(stall_cycles), 64'(20));
        chk("sat_hold_result", 64'(out_result), 64'(32'hABC));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
